// File: rtl/shared_pkg.sv
// Bus widths and APB master state encoding shared across the APB subsystem.
package shared_pkg;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_mst_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin APB master: shares one APB slave between NUM_REQ requesters,
// with a wait-state timeout so a hung slave cannot lock the bus.
module apb_master_arbiter
  import shared_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic                          PSELx,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [STRB_WIDTH-1:0]         PSTRB,
  input  logic                          PREADY,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PSLVERR
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  apb_mst_state_e     state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(arb_grant),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Accept is combinational so the request is consumed in the grant cycle itself.
  assign req_ready = (state == IDLE && !PRESET) ? arb_grant : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      tmo_cnt   <= '0;
      PADDR     <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            gnt_idx <= arb_idx;
            rr_ptr  <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            PADDR   <= req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
            PWRITE  <= req_write[arb_idx];
            // Write data and strobes are forced to zero on reads.
            PWDATA  <= req_write[arb_idx] ? req_wdata[arb_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
            PSTRB   <= req_write[arb_idx] ? req_strb[arb_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
            PSELx   <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          tmo_cnt <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= NUM_REQ'(1) << gnt_idx;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= PSLVERR;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= NUM_REQ'(1) << gnt_idx;
            rsp_err   <= 1'b1;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter with a simple APB slave model.
module tb_apb_master_arbiter;
  import shared_pkg::*;

  localparam int NR = 4;

  logic                     PCLK = 1'b0;
  logic                     PRESET;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR*ADDR_WIDTH-1:0] req_addr;
  logic [NR-1:0]            req_write;
  logic [NR*DATA_WIDTH-1:0] req_wdata;
  logic [NR*STRB_WIDTH-1:0] req_strb;
  logic [NR-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;
  logic [ADDR_WIDTH-1:0]    PADDR;
  logic                     PSELx;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [DATA_WIDTH-1:0]    PWDATA;
  logic [STRB_WIDTH-1:0]    PSTRB;
  logic                     PREADY;
  logic [DATA_WIDTH-1:0]    PRDATA;
  logic                     PSLVERR;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_arbiter #(
    .NUM_REQ       (NR),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_strb (req_strb),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PADDR    (PADDR),
    .PSELx    (PSELx),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    req_valid[r]                          = 1'b1;
    req_write[r]                          = wr;
    req_addr[r*ADDR_WIDTH +: ADDR_WIDTH]  = addr;
    req_wdata[r*DATA_WIDTH +: DATA_WIDTH] = data;
    req_strb[r*STRB_WIDTH +: STRB_WIDTH]  = strb;
  endtask

  // One complete transfer from an IDLE cycle; leaves the bench in the following IDLE cycle.
  task automatic xfer(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int waits, input logic [31:0] rd,
                      input logic serr);
    logic [31:0] exp_wd;
    logic [3:0]  exp_st;
    exp_wd = wr ? data : 32'h0;
    exp_st = wr ? strb : 4'h0;
    set_req(r, wr, addr, data, strb);
    #1;
    check("req_ready", 32'(req_ready), 1 << r);
    tick();
    req_valid[r] = 1'b0;
    PRDATA       = rd;
    PSLVERR      = serr;
    #1;
    check("setup_psel", 32'(PSELx), 1);
    check("setup_penable", 32'(PENABLE), 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", 32'(PWRITE), 32'(wr));
    check("setup_pwdata", PWDATA, exp_wd);
    check("setup_pstrb", 32'(PSTRB), 32'(exp_st));
    for (int w = 0; w <= waits; w++) begin
      tick();
      PREADY = (w == waits);
      #1;
      check("access_psel", 32'(PSELx), 1);
      check("access_penable", 32'(PENABLE), 1);
      check("access_paddr", PADDR, addr);
      check("access_pwdata", PWDATA, exp_wd);
      check("access_pstrb", 32'(PSTRB), 32'(exp_st));
      check("access_no_rsp", 32'(rsp_valid), 0);
    end
    tick();
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    #1;
    check("rsp_valid", 32'(rsp_valid), 1 << r);
    check("rsp_err", 32'(rsp_err), 32'(serr));
    check("rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
    check("rsp_idle_psel", 32'(PSELx), 0);
    tick();
    #1;
    check("rsp_pulse_end", 32'(rsp_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    PREADY    = 1'b1;
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    tick();
    tick();
    PRESET = 1'b0;
    #1;
    check("rst_psel", 32'(PSELx), 0);
    check("rst_penable", 32'(PENABLE), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 0);

    // Fairness: all requesters held high, grants rotate 0,1,2,3,0,1,2,3.
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'h0);
    #1;
    for (int k = 0; k < 8; k++) begin
      check("fair_ready", 32'(req_ready), 1 << (k % 4));
      tick();
      if (k == 7) req_valid = '0;
      tick();
      tick();
      check("fair_rsp", 32'(rsp_valid), 1 << (k % 4));
    end
    tick();

    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
    xfer(2, 1'b0, 32'h08, 32'hFFFF0000, 4'hF, 3, 32'h12345678, 1'b0);
    xfer(1, 1'b1, 32'hFC, 32'hCAFEF00D, 4'h3, 0, 32'h0, 1'b1);
    xfer(3, 1'b0, 32'h10, 32'h0, 4'h0, 1, 32'hA5A55A5A, 1'b0);

    // Timeout: slave never raises PREADY; abort after the 16th ACCESS cycle.
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;
    check("tmo_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    PREADY    = 1'b0;
    PRDATA    = 32'hFFFFFFFF;
    for (int w = 0; w < 16; w++) begin
      tick();
      check("tmo_access_penable", 32'(PENABLE), 1);
      check("tmo_access_no_rsp", 32'(rsp_valid), 0);
    end
    tick();
    check("tmo_rsp_valid", 32'(rsp_valid), 32'h2);
    check("tmo_rsp_err", 32'(rsp_err), 1);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    check("tmo_psel", 32'(PSELx), 0);
    PREADY = 1'b1;
    PRDATA = 32'h0;
    tick();

    // Reset during an ACCESS wait state drops the transfer silently.
    set_req(2, 1'b1, 32'h30, 32'h11223344, 4'hF);
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    PREADY    = 1'b0;
    tick();
    tick();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    PREADY = 1'b1;
    check("mid_rst_psel", 32'(PSELx), 0);
    check("mid_rst_penable", 32'(PENABLE), 0);
    check("mid_rst_paddr", PADDR, 0);
    check("mid_rst_pwdata", PWDATA, 0);
    check("mid_rst_pstrb", 32'(PSTRB), 0);
    check("mid_rst_pwrite", 32'(PWRITE), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_rsp_err", 32'(rsp_err), 0);
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_rr_ptr", 32'(dut.rr_ptr), 0);
    tick();
    check("mid_rst_no_late_rsp", 32'(rsp_valid), 0);

    xfer(3, 1'b0, 32'h0C, 32'h0, 4'h0, 0, 32'h0BADCAFE, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
